fmv_display_frame_sched: RTL and testbench
==========================================

FMV_DISPLAY_FRAME_SCHED -- requirements
Module: fmv_display_frame_sched

Interface
REQ-001 clk  input  1  system clock; all logic on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 vsync  input  1  single-cycle pulse marking the start of a display field.
REQ-004 playing  input  1  high = advance frames; low = freeze the current frame.
REQ-005 flush  input  1  single-cycle pulse: release every held frame and drain the queue.
REQ-006 fields_per_frame  input  3  fields each decoded frame is shown; 0 is treated as 1.
REQ-007 fifo_valid  input  1  decoded-frame address queue is non-empty.
REQ-008 fifo_q  input  planar_yuv_s  head of the address queue.
REQ-009 fifo_strobe  output  1  one-cycle pop of the queue head.
REQ-010 frame_adr  output  planar_yuv_s  Y/U/V base addresses of the displayed frame.
REQ-011 frame_adr_valid  output  1  frame_adr holds a real frame.
REQ-012 release_we  output  1  one-cycle pulse returning a buffer to the free pool.
REQ-013 release_adr  output  planar_yuv_s  buffer being returned; valid only while release_we is high.
REQ-014 underrun_cnt  output  8  saturating count of fields where a new frame was due but none was available.

Function
REQ-015 States: IDLE (no frame), SHOW (frame displayed), LOCK (post-pop settle), FLUSH (draining).
REQ-016 The queue output is registered with 1-cycle latency, so after any fifo_strobe the block shall ignore fifo_valid and fifo_q for 2 cycles (LOCK).
REQ-017 Pop rule: fifo_strobe is asserted in the same cycle fifo_q is captured; there shall never be more than one strobe in any 3 consecutive cycles.
REQ-018 IDLE, vsync, playing, fifo_valid -> capture fifo_q into frame_adr, strobe, set frame_adr_valid, load field_cnt = max(fields_per_frame, 1) - 1, go to LOCK, then SHOW.
REQ-019 SHOW, vsync, field_cnt > 0 -> decrement field_cnt.
REQ-020 SHOW, vsync, field_cnt = 0, playing, fifo_valid -> swap in fifo_q as in REQ-018, and pulse release_we with the old frame_adr in the same cycle.
REQ-021 SHOW, vsync, field_cnt = 0, playing, !fifo_valid -> keep the frame and increment underrun_cnt (saturate at 255); field_cnt stays 0 so the next vsync retries.
REQ-022 With playing low, vsync changes neither field_cnt nor underrun_cnt, and no pop occurs.
REQ-023 A vsync arriving in LOCK or FLUSH is ignored, except that a vsync in LOCK after REQ-020 still decrements a non-zero field_cnt.
REQ-024 flush in any state -> FLUSH. If frame_adr_valid, release frame_adr next cycle and clear frame_adr_valid. Then, while fifo_valid, pop and release each head with strobe and release in the same cycle, one per 3 cycles. Go to IDLE once fifo_valid is low after the 2-cycle settle.
REQ-025 A flush that coincides with vsync wins; the vsync is discarded.
REQ-026 A flush during FLUSH restarts nothing and is absorbed.
REQ-027 fields_per_frame is sampled only when field_cnt is loaded.
REQ-028 release_we shall never pulse for an address that was not previously captured.

Reset
REQ-029 Reset forces IDLE and clears field_cnt, underrun_cnt, fifo_strobe, release_we, and frame_adr_valid to 0; frame_adr and release_adr are set to all zero.
REQ-030 A reset asserted mid-operation (including during FLUSH) produces no release pulse and no pop; buffers are reclaimed by the allocator's own reset.

Structure
REQ-031 planar_yuv_s and a state enum type shall live in the shared mpeg util package; the 3-cycle pop spacing constant shall also be there.
REQ-032 The block is a single module with no sub-modules; the address queue stays external.

Verification
REQ-033 fifo_valid with A, fields_per_frame=2, three vsyncs while playing -> pop at vsync 1; frame_adr=A on the next cycle; no pop at vsync 2; at vsync 3 with B queued, frame_adr=B and release_adr=A.
REQ-034 Queue empty when a swap is due, then 3 vsyncs -> underrun_cnt=3 and frame unchanged; with B enqueued, next vsync swaps.
REQ-035 Flush with current frame A and queue holding B, C -> releases A, B, C in order; pops spaced ≥3 cycles; ends IDLE with frame_adr_valid=0.
REQ-036 fields_per_frame=0 -> new frame every vsync; playing=0 -> no pops and underrun_cnt constant across 4 vsyncs.
REQ-037 Reset asserted one cycle after a pop -> no release_we pulse and all outputs zero next cycle.
REQ-038 underrun_cnt driven past 255 -> holds 255.

Source files
------------

// File: rtl/fmv_display_frame_sched_pkg.sv
// fmv_display_frame_sched_pkg: shared mpeg util types and constants for display frame scheduling.
package fmv_display_frame_sched_pkg;

    localparam int ADR_W   = 16;
    localparam int POP_GAP = 3;

    typedef struct packed {
        logic [ADR_W-1:0] y;
        logic [ADR_W-1:0] u;
        logic [ADR_W-1:0] v;
    } planar_yuv_s;

    typedef enum logic [1:0] {IDLE, SHOW, LOCK, FLUSH} sched_state_e;

    function automatic logic [2:0] first_field_cnt(input logic [2:0] fpf);
        return (fpf == 3'd0) ? 3'd0 : fpf - 3'd1;
    endfunction

endpackage

// File: rtl/fmv_display_frame_sched.sv
// fmv_display_frame_sched: picks the displayed frame per field, pops the decoded-frame queue,
// and returns retired buffers to the free pool.
module fmv_display_frame_sched
    import fmv_display_frame_sched_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync,
    input  logic        playing,
    input  logic        flush,
    input  logic [2:0]  fields_per_frame,
    input  logic        fifo_valid,
    input  planar_yuv_s fifo_q,
    output logic        fifo_strobe,
    output planar_yuv_s frame_adr,
    output logic        frame_adr_valid,
    output logic        release_we,
    output planar_yuv_s release_adr,
    output logic [7:0]  underrun_cnt
);

    localparam logic [1:0] GAP = 2'(POP_GAP - 1);

    sched_state_e state_q;
    logic [2:0]   field_cnt_q;
    logic [1:0]   gap_q;
    logic         lock_swap_q;
    logic         strobe_q;
    logic         valid_q;
    logic         release_we_q;
    logic [7:0]   underrun_q;
    planar_yuv_s  frame_adr_q;
    planar_yuv_s  release_adr_q;

    assign fifo_strobe     = strobe_q;
    assign frame_adr       = frame_adr_q;
    assign frame_adr_valid = valid_q;
    assign release_we      = release_we_q;
    assign release_adr     = release_adr_q;
    assign underrun_cnt    = underrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            field_cnt_q   <= '0;
            gap_q         <= '0;
            lock_swap_q   <= 1'b0;
            strobe_q      <= 1'b0;
            valid_q       <= 1'b0;
            release_we_q  <= 1'b0;
            underrun_q    <= '0;
            frame_adr_q   <= '0;
            release_adr_q <= '0;
        end else begin
            strobe_q     <= 1'b0;
            release_we_q <= 1'b0;
            // flush outranks any coincident vsync; a repeat flush while draining is absorbed
            if (flush && state_q != FLUSH) begin
                state_q       <= FLUSH;
                gap_q         <= GAP;
                release_we_q  <= valid_q;
                release_adr_q <= frame_adr_q;
                valid_q       <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (vsync && playing && fifo_valid) begin
                        frame_adr_q <= fifo_q;
                        strobe_q    <= 1'b1;
                        valid_q     <= 1'b1;
                        field_cnt_q <= first_field_cnt(fields_per_frame);
                        gap_q       <= GAP;
                        lock_swap_q <= 1'b0;
                        state_q     <= LOCK;
                    end
                    SHOW: if (vsync && playing) begin
                        if (field_cnt_q != 3'd0) begin
                            field_cnt_q <= field_cnt_q - 3'd1;
                        end else if (fifo_valid) begin
                            release_we_q  <= 1'b1;
                            release_adr_q <= frame_adr_q;
                            frame_adr_q   <= fifo_q;
                            strobe_q      <= 1'b1;
                            field_cnt_q   <= first_field_cnt(fields_per_frame);
                            gap_q         <= GAP;
                            lock_swap_q   <= 1'b1;
                            state_q       <= LOCK;
                        end else if (underrun_q != 8'hff) begin
                            underrun_q <= underrun_q + 8'd1;
                        end
                    end
                    LOCK: begin
                        gap_q <= gap_q - 2'd1;
                        if (gap_q == 2'd1) state_q <= SHOW;
                        if (vsync && playing && lock_swap_q && field_cnt_q != 3'd0)
                            field_cnt_q <= field_cnt_q - 3'd1;
                    end
                    FLUSH: begin
                        if (gap_q != 2'd0) begin
                            gap_q <= gap_q - 2'd1;
                        end else if (fifo_valid) begin
                            strobe_q      <= 1'b1;
                            release_we_q  <= 1'b1;
                            release_adr_q <= fifo_q;
                            gap_q         <= GAP;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fmv_display_frame_sched.sv
// tb_fmv_display_frame_sched: directed checks of frame scheduling, underrun, flush and reset.
module tb_fmv_display_frame_sched;
    import fmv_display_frame_sched_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vsync = 1'b0;
    logic        playing = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  fields_per_frame = 3'd2;
    logic        fifo_valid = 1'b0;
    planar_yuv_s fifo_q = '0;
    logic        fifo_strobe;
    planar_yuv_s frame_adr;
    logic        frame_adr_valid;
    logic        release_we;
    planar_yuv_s release_adr;
    logic [7:0]  underrun_cnt;

    int total = 0;
    int bad = 0;
    int hd = 0;
    int tl = 0;
    int cyc = 0;
    int last_pop = -100;
    int min_gap = 1000;
    int str_n = 0;
    int rel_n = 0;
    planar_yuv_s rel_log [64];

    fmv_display_frame_sched dut (
        .clk(clk), .reset(reset), .vsync(vsync), .playing(playing), .flush(flush),
        .fields_per_frame(fields_per_frame), .fifo_valid(fifo_valid), .fifo_q(fifo_q),
        .fifo_strobe(fifo_strobe), .frame_adr(frame_adr), .frame_adr_valid(frame_adr_valid),
        .release_we(release_we), .release_adr(release_adr), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    function automatic planar_yuv_s mk(input int n);
        planar_yuv_s r;
        r.y = 16'(32'h1000 + n);
        r.u = 16'(32'h2000 + n);
        r.v = 16'(32'h3000 + n);
        return r;
    endfunction

    // external queue with registered head: output reflects a pop one edge after it is seen
    always @(posedge clk) begin
        if (fifo_strobe) hd <= hd + 1;
        fifo_valid <= (hd < tl);
        fifo_q     <= mk(hd);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_strobe) begin
            str_n    <= str_n + 1;
            last_pop <= cyc;
            if (cyc - last_pop < min_gap) min_gap <= cyc - last_pop;
        end
        if (release_we) begin
            rel_log[rel_n] <= release_adr;
            rel_n          <= rel_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vs();
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
    endtask

    initial begin
        int s0;
        int u0;
        int r0;
        tick(2);
        chk("rst_valid", 64'(frame_adr_valid), 64'(0));
        chk("rst_adr", 64'(frame_adr), 64'(0));
        chk("rst_underrun", 64'(underrun_cnt), 64'(0));
        chk("rst_strobe", 64'(fifo_strobe), 64'(0));
        chk("rst_release", 64'(release_we), 64'(0));
        reset = 1'b0;
        playing = 1'b1;
        fields_per_frame = 3'd2;
        tl = 1;
        tick(3);
        vs();
        chk("v1_strobe", 64'(fifo_strobe), 64'(1));
        chk("v1_adr", 64'(frame_adr), 64'(mk(0)));
        chk("v1_valid", 64'(frame_adr_valid), 64'(1));
        tl = 2;
        tick(3);
        vs();
        chk("v2_nopop", 64'(fifo_strobe), 64'(0));
        chk("v2_adr", 64'(frame_adr), 64'(mk(0)));
        tick(3);
        vs();
        chk("v3_strobe", 64'(fifo_strobe), 64'(1));
        chk("v3_adr", 64'(frame_adr), 64'(mk(1)));
        chk("v3_rel_we", 64'(release_we), 64'(1));
        chk("v3_rel_adr", 64'(release_adr), 64'(mk(0)));
        tick(4);
        vs();
        repeat (3) begin
            tick(1);
            vs();
        end
        chk("ur_cnt3", 64'(underrun_cnt), 64'(3));
        chk("ur_adr", 64'(frame_adr), 64'(mk(1)));
        tl = 3;
        tick(3);
        vs();
        chk("ur_swap_adr", 64'(frame_adr), 64'(mk(2)));
        chk("ur_swap_rel", 64'(release_adr), 64'(mk(1)));
        chk("ur_hold", 64'(underrun_cnt), 64'(3));
        tl = 5;
        tick(4);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        tick(20);
        chk("fl_rel_n", 64'(rel_n), 64'(5));
        chk("fl_rel0", 64'(rel_log[0]), 64'(mk(0)));
        chk("fl_rel2", 64'(rel_log[2]), 64'(mk(2)));
        chk("fl_rel3", 64'(rel_log[3]), 64'(mk(3)));
        chk("fl_rel4", 64'(rel_log[4]), 64'(mk(4)));
        chk("fl_valid", 64'(frame_adr_valid), 64'(0));
        s0 = str_n;
        vs();
        tick(2);
        chk("idle_empty_nopop", 64'(str_n), 64'(s0));
        fields_per_frame = 3'd0;
        tl = 6;
        tick(3);
        vs();
        chk("idle_capture", 64'(frame_adr), 64'(mk(5)));
        tl = 8;
        tick(3);
        vs();
        chk("fpf0_g", 64'(frame_adr), 64'(mk(6)));
        tick(3);
        vs();
        chk("fpf0_h", 64'(frame_adr), 64'(mk(7)));
        playing = 1'b0;
        tl = 9;
        tick(3);
        s0 = str_n;
        u0 = int'(underrun_cnt);
        repeat (4) begin
            vs();
            tick(2);
        end
        chk("pause_nopop", 64'(str_n), 64'(s0));
        chk("pause_underrun", 64'(underrun_cnt), 64'(u0));
        chk("pause_adr", 64'(frame_adr), 64'(mk(7)));
        playing = 1'b1;
        vs();
        chk("resume_adr", 64'(frame_adr), 64'(mk(8)));
        tick(3);
        repeat (251) begin
            vs();
            tick(1);
        end
        chk("sat_254", 64'(underrun_cnt), 64'(254));
        vs();
        tick(1);
        chk("sat_255", 64'(underrun_cnt), 64'(255));
        repeat (5) begin
            vs();
            tick(1);
        end
        chk("sat_hold", 64'(underrun_cnt), 64'(255));
        tl = 10;
        tick(3);
        vs();
        chk("pre_rst_pop", 64'(fifo_strobe), 64'(1));
        reset = 1'b1;
        tick(1);
        r0 = rel_n;
        chk("rst_mid_strobe", 64'(fifo_strobe), 64'(0));
        chk("rst_mid_rel", 64'(release_we), 64'(0));
        chk("rst_mid_adr", 64'(frame_adr), 64'(0));
        chk("rst_mid_valid", 64'(frame_adr_valid), 64'(0));
        chk("rst_mid_underrun", 64'(underrun_cnt), 64'(0));
        chk("rst_mid_rel_adr", 64'(release_adr), 64'(0));
        tick(2);
        reset = 1'b0;
        tick(2);
        chk("rst_no_release", 64'(rel_n), 64'(r0));
        chk("rst_last_rel", 64'(rel_log[r0-1]), 64'(mk(8)));
        chk("pop_spacing_ok", 64'(min_gap >= POP_GAP), 64'(1));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
